// File: rtl/wb_8bit_fifo_to_32bit_reader_if.sv
// wb_8bit_fifo_to_32bit_reader_if: Wishbone slave bus bundle for the FIFO reader
interface wb_8bit_fifo_to_32bit_reader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_sel_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_8bit_fifo_to_32bit_reader.sv
// wb_8bit_fifo_to_32bit_reader: Wishbone slave assembling little-endian 32-bit reads from an 8-bit FIFO
module wb_8bit_fifo_to_32bit_reader #(
  parameter int DPTH_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  wb_8bit_fifo_to_32bit_reader_if.slave        wbs,
  input  logic [7:0]                           rd_dat_i,
  output logic                                 rd_ena_o,
  input  logic                                 rd_empty_i,
  input  logic [DPTH_W:0]                      rd_num_i
);
  typedef enum logic [2:0] {IDLE, WAIT, POP, ACK, ERR} state_t;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  state_t state, state_nxt;
  logic [3:0] sel_q;
  logic [3:0] lane;
  logic [2:0] n;
  logic [31:0] tmr;
  logic aborted, req, last, timed_out;
  logic unused;
  assign unused = ^{wbs.wbs_dat_i, wbs.wbs_adr_i[31:3], wbs.wbs_adr_i[1:0]};
  assign req = wbs.wbs_cyc_i && wbs.wbs_stb_i;
  // sel_q holds the lanes still waiting for a byte; lowest pending lane is filled next
  assign lane = sel_q & (~sel_q + 4'd1);
  assign last = (sel_q & (sel_q - 4'd1)) == 4'd0;
  assign n = 3'(sel_q[0]) + 3'(sel_q[1]) + 3'(sel_q[2]) + 3'(sel_q[3]);
  assign timed_out = (TIMEOUT != 0) && (tmr == TO_LAST);
  assign rd_ena_o = state == POP;
  assign wbs.wbs_ack_o = (state == ACK) && wbs.wbs_cyc_i;
  assign wbs.wbs_err_o = (state == ERR) && wbs.wbs_cyc_i;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = wbs.wbs_we_i ? ERR : (wbs.wbs_adr_i[2] || wbs.wbs_sel_i == 4'd0) ? ACK : WAIT;
      WAIT: state_nxt = !wbs.wbs_cyc_i ? IDLE : (rd_num_i >= (DPTH_W+1)'(n)) ? POP : timed_out ? ERR : WAIT;
      POP:  if (last) state_nxt = (aborted || !wbs.wbs_cyc_i) ? IDLE : ACK;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      sel_q         <= 4'd0;
      tmr           <= 32'd0;
      aborted       <= 1'b0;
      wbs.wbs_dat_o <= 32'd0;
    end else begin
      state <= state_nxt;
      tmr   <= (state == WAIT) ? tmr + 32'd1 : 32'd0;
      if (state == IDLE && req) begin
        sel_q         <= wbs.wbs_sel_i;
        aborted       <= 1'b0;
        wbs.wbs_dat_o <= (wbs.wbs_adr_i[2] && !wbs.wbs_we_i) ? 32'({rd_num_i, rd_empty_i}) : 32'd0;
      end
      // an abort mid-burst still drains all bytes so the FIFO stays word aligned
      if (state == POP) begin
        sel_q   <= sel_q & ~lane;
        aborted <= aborted | ~wbs.wbs_cyc_i;
        for (int i = 0; i < 4; i++)
          if (lane[i]) wbs.wbs_dat_o[8*i +: 8] <= rd_dat_i;
      end
    end
  end
endmodule

// File: tb/tb_wb_8bit_fifo_to_32bit_reader.sv
// tb_wb_8bit_fifo_to_32bit_reader: self-checking bench with a queue-based FIFO and transaction-level model
module tb_wb_8bit_fifo_to_32bit_reader;
  localparam int TO = 16;
  logic clk, rst_i;
  logic [7:0] rd_dat_i;
  logic rd_ena_o, rd_empty_i;
  logic [8:0] rd_num_i;
  wb_8bit_fifo_to_32bit_reader_if wb();
  wb_8bit_fifo_to_32bit_reader #(.DPTH_W(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .wbs(wb),
    .rd_dat_i(rd_dat_i), .rd_ena_o(rd_ena_o), .rd_empty_i(rd_empty_i), .rd_num_i(rd_num_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic we; logic a2; logic [3:0] sel; int push; int lat; logic ack; logic err;
  } vec_t;
  vec_t tbl[10];
  logic [7:0] fifo[$];
  int checks = 0, errors = 0, pops = 0, empty_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic upd();
    rd_dat_i   = fifo.size() > 0 ? fifo[0] : 8'h00;
    rd_empty_i = fifo.size() == 0;
    rd_num_i   = 9'(fifo.size());
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    upd();
  endtask

  // one clock: account for a pop requested this cycle, then sample #1 after the edge
  task automatic step();
    logic p;
    p = rd_ena_o;
    if (p) begin
      pops++;
      if (fifo.size() == 0) empty_pops++;
    end
    @(posedge clk);
    #1;
    if (p && fifo.size() > 0) void'(fifo.pop_front());
    upd();
  endtask

  task automatic bus(input logic c, input logic we, input logic a2, input logic [3:0] sel);
    wb.wbs_cyc_i = c; wb.wbs_stb_i = c; wb.wbs_we_i = we;
    wb.wbs_adr_i = {$urandom} & 32'hFFFF_FFF3 | {29'd0, a2, 2'b00};
    wb.wbs_sel_i = sel; wb.wbs_dat_i = $urandom;
  endtask

  function automatic int ones(input logic [3:0] s);
    return int'(s[0]) + int'(s[1]) + int'(s[2]) + int'(s[3]);
  endfunction

  // reference: status word or selected lanes filled in order from the queue head
  function automatic logic [31:0] model_dat(input logic we, input logic a2, input logic [3:0] sel);
    logic [31:0] d;
    int k;
    d = 32'd0; k = 0;
    if (we) return 32'd0;
    if (a2) return 32'({9'(fifo.size()), fifo.size() == 0});
    for (int l = 0; l < 4; l++)
      if (sel[l]) begin
        d[8*l +: 8] = fifo[k];
        k++;
      end
    return d;
  endfunction

  task automatic xfer(input logic we, input logic a2, input logic [3:0] sel, input int budget,
                      output int lat, output logic [31:0] d, output logic ga, output logic ge);
    bus(1'b1, we, a2, sel);
    lat = -1; d = 32'd0; ga = 1'b0; ge = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (wb.wbs_ack_o || wb.wbs_err_o) begin
        lat = c + 1; ga = wb.wbs_ack_o; ge = wb.wbs_err_o; d = wb.wbs_dat_o;
        break;
      end
    end
    bus(1'b0, 1'b0, 1'b0, 4'd0);
    step();
  endtask

  task automatic run(input string nm, input logic we, input logic a2, input logic [3:0] sel,
                     input int elat, input logic eack, input logic eerr, input logic [31:0] edat, input int epops);
    int lat, p0, s0;
    logic [31:0] d;
    logic ga, ge;
    p0 = pops; s0 = fifo.size();
    xfer(we, a2, sel, 60, lat, d, ga, ge);
    if (elat == TO + 1) chk({nm, "_lat_window"}, 32'(lat >= TO && lat <= TO + 2), 32'd1);
    else chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_ack"}, 32'(ga), 32'(eack));
    chk({nm, "_err"}, 32'(ge), 32'(eerr));
    if (eack) chk({nm, "_dat"}, d, edat);
    chk({nm, "_pops"}, 32'(pops - p0), 32'(epops));
    chk({nm, "_fifo_left"}, 32'(fifo.size()), 32'(s0 - epops));
  endtask

  initial begin
    int p0, lat, acks, errs;
    logic [31:0] d;
    logic we, a2;
    logic [3:0] sel;
    tbl[0] = '{1'b0, 1'b0, 4'hF, 4, 6, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'hA, 2, 4, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 0, 1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'hF, 5, 1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'hF, 0, 1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 4'h3, 0, 1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'h7, 0, 5, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'h9, 0, 4, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 4'hF, 0, 1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 4'h1, 1, 3, 1'b1, 1'b0};
    rst_i = 1'b1;
    bus(1'b0, 1'b0, 1'b0, 4'd0);
    upd();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    chk("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_err", 32'(wb.wbs_err_o), 32'd0);
    chk("rst_rd_ena", 32'(rd_ena_o), 32'd0);
    rst_i = 1'b0;
    step();

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run("plan_word", 1'b0, 1'b0, 4'hF, 6, 1'b1, 1'b0, 32'h4433_2211, 4);
    push(8'hAA); push(8'hBB);
    run("plan_sel_a", 1'b0, 1'b0, 4'b1010, 4, 1'b1, 1'b0, 32'hBB00_AA00, 2);

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < tbl[i].push; b++) push(8'($urandom));
      run($sformatf("tbl%0d", i), tbl[i].we, tbl[i].a2, tbl[i].sel, tbl[i].lat, tbl[i].ack, tbl[i].err,
          model_dat(tbl[i].we, tbl[i].a2, tbl[i].sel),
          (tbl[i].ack && !tbl[i].a2) ? ones(tbl[i].sel) : 0);
    end

    // short FIFO: request stalls in WAIT until more bytes arrive at cycle 10
    push(8'h11); push(8'h22);
    p0 = pops; acks = 0; lat = -1; d = 32'd0;
    bus(1'b1, 1'b0, 1'b0, 4'hF);
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 9) chk("stall_no_pops", 32'(pops - p0), 32'd0);
      if (c == 10) begin push(8'h33); push(8'h44); end
      if (wb.wbs_ack_o) begin
        acks++;
        if (lat < 0) begin lat = c; d = wb.wbs_dat_o; end
        bus(1'b0, 1'b0, 1'b0, 4'd0);
      end
    end
    chk("stall_lat", 32'(lat), 32'd15);
    chk("stall_acks", 32'(acks), 32'd1);
    chk("stall_dat", d, 32'h4433_2211);
    chk("stall_pops", 32'(pops - p0), 32'd4);

    run("timeout", 1'b0, 1'b0, 4'hF, TO + 1, 1'b0, 1'b1, 32'd0, 0);

    // abort while waiting on an empty FIFO
    p0 = pops; acks = 0; errs = 0;
    bus(1'b1, 1'b0, 1'b0, 4'hF);
    repeat (3) step();
    bus(1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 25; c++) begin
      step();
      acks += int'(wb.wbs_ack_o);
      errs += int'(wb.wbs_err_o);
    end
    chk("abort_wait_resp", 32'(acks + errs), 32'd0);
    chk("abort_wait_pops", 32'(pops - p0), 32'd0);

    // abort after the second pop: burst completes, no ack
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    p0 = pops; acks = 0; errs = 0;
    bus(1'b1, 1'b0, 1'b0, 4'hF);
    repeat (4) step();
    chk("abort_pop_midway", 32'(pops - p0), 32'd2);
    bus(1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 8; c++) begin
      step();
      acks += int'(wb.wbs_ack_o);
      errs += int'(wb.wbs_err_o);
    end
    chk("abort_pop_resp", 32'(acks + errs), 32'd0);
    chk("abort_pop_pops", 32'(pops - p0), 32'd4);
    chk("abort_pop_fifo", 32'(fifo.size()), 32'd0);

    // async reset in the middle of a burst
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    bus(1'b1, 1'b0, 1'b0, 4'hF);
    repeat (3) step();
    chk("rst_pop_active", 32'(rd_ena_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_pop_ena", 32'(rd_ena_o), 32'd0);
    chk("rst_pop_ack", 32'(wb.wbs_ack_o), 32'd0);
    chk("rst_pop_dat", wb.wbs_dat_o, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_pop_fifo", 32'(fifo.size()), 32'd3);
    fifo.delete();
    upd();
    step();

    // randomized transactions against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      int n, elat, ep;
      logic eack;
      repeat ($urandom_range(0, 4)) push(8'($urandom));
      we = $urandom_range(0, 7) == 0;
      a2 = $urandom_range(0, 3) == 0;
      sel = 4'($urandom);
      n = ones(sel);
      eack = 1'b1; ep = 0;
      if (we) begin elat = 1; eack = 1'b0; end
      else if (a2 || n == 0) elat = 1;
      else if (fifo.size() >= n) begin elat = n + 2; ep = n; end
      else begin elat = TO + 1; eack = 1'b0; end
      run($sformatf("rnd%0d", t), we, a2, sel, elat, eack, !eack, model_dat(we, a2, sel), ep);
    end

    chk("no_pop_when_empty", 32'(empty_pops), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
